// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver (8N1-style, no parity) with 2-of-3 mid-bit voting into a one-entry valid/ready holding register.
// Byte appears one cycle after the stop-bit vote; a full, undrained holding register drops the new byte and pulses overrun.
module uart_rx_oversampled #(
  parameter int CLK_FREQUENCY = 100000000,
  parameter int BAUD_RATE     = 115200,
  parameter int DATA_BITS     = 8,
  parameter int OVERSAMPLE    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_busy,
  output logic                 framing_error,
  output logic                 overrun
);

  localparam int DIV = CLK_FREQUENCY / (BAUD_RATE * OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_V0   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_V1   = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_V2   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  logic                 sync1_q, sync2_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  state_t               state_q, state_d;
  logic [SW-1:0]        s_q, s_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [1:0]           v_q, v_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 deliver_q, deliver_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 fe_q, fe_d;
  logic                 ovr_q, ovr_d;

  logic                 rx_s;
  logic                 tick;
  logic                 sampling;
  logic                 vote;
  logic [SW-1:0]        s_nxt;
  logic [DATA_BITS:0]   shift_ext;

  assign rx_s      = sync2_q;
  assign tick      = (cnt_q == C_LAST);
  assign s_nxt     = (s_q == S_LAST) ? '0 : s_q + SW'(1);
  // Third vote sample is the live synchronized bit on the S_V2 tick.
  assign vote      = (v_q[0] & v_q[1]) | (v_q[0] & rx_s) | (v_q[1] & rx_s);
  assign shift_ext = {vote, shift_q};
  assign sampling  = tick && (state_q == ST_START || state_q == ST_DATA || state_q == ST_STOP);

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      cnt_q     <= '0;
      state_q   <= ST_IDLE;
      s_q       <= '0;
      bit_q     <= '0;
      v_q       <= '0;
      shift_q   <= '0;
      deliver_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      sync1_q   <= rx_serial;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      s_q       <= s_d;
      bit_q     <= bit_d;
      v_q       <= v_d;
      shift_q   <= shift_d;
      deliver_q <= deliver_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    cnt_d     = tick ? '0 : cnt_q + CW'(1);
    state_d   = state_q;
    s_d       = s_q;
    bit_d     = bit_q;
    v_d       = v_q;
    shift_d   = shift_q;
    deliver_d = 1'b0;
    data_d    = data_q;
    valid_d   = valid_q;
    fe_d      = 1'b0;
    ovr_d     = 1'b0;

    if (sampling) begin
      s_d = s_nxt;
      if (s_nxt == S_V0) v_d[0] = rx_s;
      if (s_nxt == S_V1) v_d[1] = rx_s;
    end

    case (state_q)
      ST_IDLE: begin
        // The detecting tick itself is sample 0 of the start bit.
        if (tick && !rx_s) begin
          state_d = ST_START;
          s_d     = '0;
        end
      end
      ST_START: begin
        if (sampling) begin
          if (s_nxt == S_V2 && vote) begin
            state_d = ST_IDLE;
          end else if (s_nxt == S_LAST) begin
            state_d = ST_DATA;
            bit_d   = '0;
          end
        end
      end
      ST_DATA: begin
        if (sampling) begin
          if (s_nxt == S_V2) shift_d = shift_ext[DATA_BITS:1];
          if (s_nxt == S_LAST) begin
            if (bit_q == B_LAST) state_d = ST_STOP;
            else                 bit_d   = bit_q + BW'(1);
          end
        end
      end
      ST_STOP: begin
        // Decide early so a back-to-back start edge is caught in IDLE.
        if (sampling && s_nxt == S_V2) begin
          if (vote) begin
            deliver_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            fe_d      = 1'b1;
            state_d   = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (tick && rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (deliver_q) begin
      if (!valid_q) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else if (rx_ready) begin
        data_d  = shift_q;
      end else begin
        ovr_d   = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  assign rx_data       = data_q;
  assign rx_valid      = valid_q;
  assign rx_busy       = (state_q != ST_IDLE);
  assign framing_error = fe_q;
  assign overrun       = ovr_q;

endmodule

// File: doc/uart_rx_oversampled.md
Name: uart_rx_oversampled

Overview:
Receive-direction UART front end. Recovers serial frames (1 start bit, DATA_BITS data bits LSB first, 1 stop bit, no parity) from rx_serial using oversampling and majority voting. Presents each byte on a one-entry valid/ready holding register that feeds the controller's output FIFO. Flags framing errors and overruns.

Parameters:
CLK_FREQUENCY, 100000000, system clock frequency in Hz
BAUD_RATE, 115200, line bit rate in bits/s
DATA_BITS, 8, data bits per frame
OVERSAMPLE, 16, sample ticks per bit period; even, >=8

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-low reset (one clock; reset is synchronous and active-low)
rx_serial  input  1  asynchronous serial line, idle high
rx_data  output  DATA_BITS  received byte; stable while rx_valid=1
rx_valid  output  1  holding register full
rx_ready  input  1  consumer accepts rx_data when rx_valid&rx_ready
rx_busy  output  1  high from start-bit detection until the frame ends or is aborted
framing_error  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: frame completed while holding register full and not drained

Behaviour:
- Reset (reset=0 at a clock edge): state IDLE, synchronizer flops=1, tick counter=0. Outputs: rx_data=0, rx_valid=0, rx_busy=0, framing_error=0, overrun=0. Reset mid-frame aborts the frame silently.
- Synchronizer: 2 flops on rx_serial. All decisions use the synchronized bit.
- Tick generator: DIV = CLK_FREQUENCY/(BAUD_RATE*OVERSAMPLE), integer truncation. Counter 0..DIV-1; one-cycle tick when counter = DIV-1, then wrap to 0. Runs freely out of reset.
- Sample index s counts ticks 0..OVERSAMPLE-1 within a bit period. The vote samples are at s = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit value is the 2-of-3 majority.
- States:
  - IDLE: on a tick with the synchronized line = 0 -> START, s=0, rx_busy=1.
  - START: vote at the mid samples. If the vote = 1 (glitch), go to IDLE immediately after the last vote sample; rx_busy=0; no error. If the vote = 0, go to DATA when s wraps at OVERSAMPLE-1.
  - DATA: vote each bit and shift it in LSB first. The bit counter runs 0..DATA_BITS-1. After bit DATA_BITS-1 wraps -> STOP.
  - STOP: decision is made at the last vote sample, without waiting for the end of the bit.
    - Vote 1 -> deliver the byte and go to IDLE; rx_busy=0 on the next cycle.
    - Vote 0 -> framing_error pulse, byte discarded, go to BREAK.
  - BREAK: wait for the synchronized line = 1 on a tick, then go to IDLE; rx_busy=0. A continuous low never retriggers a start.
- Delivery, in the cycle after the stop decision:
  - rx_valid=0: load rx_data and set rx_valid=1.
  - rx_valid=1 and rx_ready=1 in the same cycle: the old byte is consumed, the new byte loads, rx_valid stays 1.
  - rx_valid=1 and rx_ready=0: new byte dropped, old byte kept, overrun pulse.
- Handshake: rx_valid&rx_ready with no simultaneous delivery clears rx_valid next cycle. rx_ready is ignored while rx_valid=0. rx_data holds its last value when rx_valid=0.
- Latency: rx_valid rises 2 + DIV*(OVERSAMPLE/2+1) + a few cycles after the stop-bit start edge. Bench tolerance is ±1 tick.
- A start edge during STOP, after the decision, is detected in IDLE. Back-to-back frames with a one-bit stop are supported.

Test Plan:
All scenarios use CLK_FREQUENCY=1600000, BAUD_RATE=10000, OVERSAMPLE=16, DATA_BITS=8, so DIV=10 and 160 clocks per bit.
- Reset then idle line high for 2000 cycles -> rx_valid=0, rx_busy=0, no pulses; assert reset=0 mid-frame -> all outputs 0, no delivery.
- Send 0xA5 with rx_ready=1 -> rx_valid for exactly 1 cycle with rx_data=0xA5, about 1530±10 cycles after the start edge; framing_error=0.
- Send 0x3C and 0xC3 back-to-back with rx_ready=0, then raise rx_ready -> first byte 0x3C held, overrun pulses once at the second stop, 0x3C read, rx_valid=0 after.
- Send 0x55 with a stop bit forced low, line held low 5 bit times then high -> one framing_error pulse, no rx_valid; next 0x81 received correctly.
- Low glitch of 60 cycles on an idle line -> rx_busy pulses, returns to IDLE, no rx_valid, no framing_error.
- Send 0xF0 with single-tick (10-cycle) low spikes centred at sample 8 of each '1' bit -> majority vote yields rx_data=0xF0.
